// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the D-stage hazard and
//               forwarding controller (scoreboard entry layout, forwarding
//               select encoding, unused-operand Tuse marker).
// Revision    : 1.0  initial release
// ============================================================================
package hazard_pkg;

    // Default width of Tuse/Tnew fields.
    localparam int TW_DEFAULT = 2;

    // Storage width of the Tnew field inside a scoreboard entry. Any TW up to
    // this value fits; narrower TW values are zero-extended on entry.
    localparam int TW_MAX = 4;

    // Forwarding select value meaning "take the register-file read data".
    localparam int FWD_GRF = 0;

    // Tuse marker for a read port the D instruction does not use.
    localparam logic [TW_DEFAULT-1:0] TUSE_NONE = '1;

    // One in-flight destination register.
    typedef struct packed {
        logic              we;
        logic [4:0]        addr;
        logic [TW_MAX-1:0] tnew;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{we: 1'b0, addr: 5'd0, tnew: '0};

    // Saturating decrement: a result that is already available stays at 0.
    function automatic logic [TW_MAX-1:0] tnew_dec(input logic [TW_MAX-1:0] t);
        return (t == '0) ? t : (t - TW_MAX'(1));
    endfunction

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/md_busy_ctr.sv
`default_nettype none
// ============================================================================
// Module      : md_busy_ctr
// Description : Mult/div busy counter. Loads the operation latency when a
//               mult/div start leaves D and counts down to zero; busy is
//               asserted while the count is nonzero.
// Ports       : clk        - pipeline clock
//               reset      - synchronous, active-high; clears the count
//               i_load     - a start instruction is leaving D this cycle
//               i_load_div - 1 = div-class latency, 0 = mult-class latency
//               o_md_busy  - unit busy (count != 0)
// Revision    : 1.0  initial release
// ============================================================================
module md_busy_ctr #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_load_div,
    output logic o_md_busy
);

    localparam int c_max_cyc = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int c_cnt_w   = $clog2(c_max_cyc + 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_div ? c_cnt_w'(DIV_CYC) : c_cnt_w'(MULT_CYC);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_cnt_w'(1);
        end
    end

    assign o_md_busy = (r_cnt != '0);

endmodule : md_busy_ctr
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard and forwarding controller for the five-stage pipeline.
//               Tracks in-flight destination registers and their remaining
//               Tnew for every stage after D, compares them against the Tuse
//               of each D-stage source operand, and produces the stall and the
//               per-port forwarding selects. Optionally owns the mult/div
//               busy counter that gates HI/LO access.
// Config      : HAZARD_MD_EN - when defined, the mult/div busy counter and the
//               HI/LO stall term are built; otherwise md_* inputs are ignored
//               and md_busy is tied low.
// Ports       : clk, reset   - clock, synchronous active-high reset
//               valid_d      - D holds a real instruction
//               rd_addr_d    - source register of port i in [5i+4:5i]
//               tuse_d       - Tuse of port i (all-ones = port unused)
//               wa_d, we_d   - destination register / GPR write enable of D
//               tnew_d       - Tnew of D, measured at entry to E
//               md_start_d   - D starts mult/div
//               md_div_d     - 1 = div-class, 0 = mult-class
//               md_use_d     - D touches HI/LO
//               stall        - freeze PC and F/D, bubble into E
//               fwd_sel      - per port: 0 = register file, k = stage k
//               md_busy      - mult/div unit busy
// Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter  int NREAD    = 2,
    parameter  int NSTAGE   = 3,
    parameter  int TW       = TW_DEFAULT,   // must not exceed TW_MAX
    parameter  int MULT_CYC = 5,
    parameter  int DIV_CYC  = 10,
    localparam int FW       = $clog2(NSTAGE + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_d,
    input  logic [NREAD*5-1:0]    rd_addr_d,
    input  logic [NREAD*TW-1:0]   tuse_d,
    input  logic [4:0]            wa_d,
    input  logic                  we_d,
    input  logic [TW-1:0]         tnew_d,
    input  logic                  md_start_d,
    input  logic                  md_div_d,
    input  logic                  md_use_d,
    output logic                  stall,
    output logic [NREAD*FW-1:0]   fwd_sel,
    output logic                  md_busy
);

    // ------------------------------------------------------------------------
    // Scoreboard: r_sb[k] describes the instruction currently in stage k
    // (1 = E, 2 = M, 3 = W).
    // ------------------------------------------------------------------------
    sb_entry_t        r_sb [1:NSTAGE];
    sb_entry_t        w_sb_in;
    logic [NREAD-1:0] w_port_stall;
    logic             w_gpr_stall;
    logic             w_md_stall;
    logic             w_md_busy;

    // A stalled D instruction does not advance, so E receives a bubble.
    // Writes to $0 are never tracked: nothing can depend on them.
    always_comb begin
        w_sb_in = SB_EMPTY;
        if (!stall) begin
            w_sb_in.we   = valid_d & we_d & (wa_d != 5'd0);
            w_sb_in.addr = wa_d;
            w_sb_in.tnew = TW_MAX'(tnew_d);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= NSTAGE; k++) begin
                r_sb[k] <= SB_EMPTY;
            end
        end else begin
            r_sb[1] <= w_sb_in;
            for (int k = 2; k <= NSTAGE; k++) begin
                r_sb[k] <= '{we:   r_sb[k-1].we,
                             addr: r_sb[k-1].addr,
                             tnew: tnew_dec(r_sb[k-1].tnew)};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-port match, stall and forwarding select.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NREAD; i++) begin : g_port
        logic [4:0]        w_ra;
        logic [TW-1:0]     w_tuse;
        logic              w_hit;
        logic [FW-1:0]     w_stage;
        logic [TW_MAX-1:0] w_tnew;

        assign w_ra   = rd_addr_d[5*i +: 5];
        assign w_tuse = tuse_d[TW*i +: TW];

        // Scan oldest to youngest so the youngest matching stage wins; it
        // holds the most recent producer of the register.
        always_comb begin
            w_hit   = 1'b0;
            w_stage = '0;
            w_tnew  = '0;
            for (int k = NSTAGE; k >= 1; k--) begin
                if (r_sb[k].we && (r_sb[k].addr == w_ra) && (w_ra != 5'd0)) begin
                    w_hit   = 1'b1;
                    w_stage = FW'(k);
                    w_tnew  = r_sb[k].tnew;
                end
            end
        end

        // The all-ones Tuse of an unused port must never stall, even if a
        // wide Tnew would otherwise exceed it.
        assign w_port_stall[i] = w_hit && (w_tuse != '1) &&
                                 (TW_MAX'(w_tuse) < w_tnew);

        // Only forward once the youngest producer has its result; if it is
        // still computing, the operand is picked up by a later stage's
        // forwarding path (or the stall holds D until it is).
        assign fwd_sel[FW*i +: FW] = (w_hit && (w_tnew == '0)) ? w_stage
                                                               : FW'(FWD_GRF);
    end

    assign w_gpr_stall = |w_port_stall;

    // ------------------------------------------------------------------------
    // Mult/div busy tracking and HI/LO interlock.
    // ------------------------------------------------------------------------
`ifdef HAZARD_MD_EN
    logic w_md_load;

    // A start that is itself held in D must not load the counter; since start
    // instructions also assert md_use_d, a start never arrives while busy.
    assign w_md_load = valid_d & md_start_d & ~stall;

    md_busy_ctr #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_ctr (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_md_load),
        .i_load_div (md_div_d),
        .o_md_busy  (w_md_busy)
    );

    assign w_md_stall = valid_d & md_use_d & w_md_busy;
`else
    logic w_unused_md;

    assign w_unused_md = &{1'b0, md_start_d, md_div_d, md_use_d};
    assign w_md_busy   = 1'b0;
    assign w_md_stall  = 1'b0;
`endif

    assign stall   = w_gpr_stall | w_md_stall;
    assign md_busy = w_md_busy;

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl: directed vector table,
//               hand-written multi-cycle sequences (reset mid-operation,
//               mult/div interlock when HAZARD_MD_EN is defined) and a
//               randomized run against a cycle-history reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int NREAD    = 2;
    localparam int NSTAGE   = 3;
    localparam int TW       = 2;
    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;
    localparam int FW       = 2;
    localparam int NRAND    = 1200;

`ifdef HAZARD_MD_EN
    localparam bit MD_ON = 1'b1;
`else
    localparam bit MD_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              valid_d;
    logic [9:0]        rd_addr_d;
    logic [3:0]        tuse_d;
    logic [4:0]        wa_d;
    logic              we_d;
    logic [1:0]        tnew_d;
    logic              md_start_d;
    logic              md_div_d;
    logic              md_use_d;
    logic              stall;
    logic [3:0]        fwd_sel;
    logic              md_busy;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .NREAD    (NREAD),
        .NSTAGE   (NSTAGE),
        .TW       (TW),
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_d    (valid_d),
        .rd_addr_d  (rd_addr_d),
        .tuse_d     (tuse_d),
        .wa_d       (wa_d),
        .we_d       (we_d),
        .tnew_d     (tnew_d),
        .md_start_d (md_start_d),
        .md_div_d   (md_div_d),
        .md_use_d   (md_use_d),
        .stall      (stall),
        .fwd_sel    (fwd_sel),
        .md_busy    (md_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit v,
                         input logic [4:0] r0, input logic [4:0] r1,
                         input logic [1:0] t0, input logic [1:0] t1,
                         input logic [4:0] wa, input bit we, input logic [1:0] tn,
                         input bit ms, input bit mdv, input bit mu);
        reset      = rst;
        valid_d    = v;
        rd_addr_d  = {r1, r0};
        tuse_d     = {t1, t0};
        wa_d       = wa;
        we_d       = we;
        tnew_d     = tn;
        md_start_d = ms;
        md_div_d   = mdv;
        md_use_d   = mu;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table (GPR path only).
    // ------------------------------------------------------------------------
    typedef struct {
        bit         rst;
        bit         do_chk;
        bit         v;
        logic [4:0] r0;
        logic [1:0] t0;
        logic [4:0] r1;
        logic [1:0] t1;
        logic [4:0] wa;
        bit         we;
        logic [1:0] tn;
        bit         e_stall;
        int         e_f0;
        int         e_f1;
    } vec_t;

    function automatic vec_t mkv(bit rst, bit c, bit v, logic [4:0] r0, logic [1:0] t0,
                                 logic [4:0] r1, logic [1:0] t1, logic [4:0] wa, bit we,
                                 logic [1:0] tn, bit es, int f0, int f1);
        vec_t x;
        x.rst = rst; x.do_chk = c; x.v = v; x.r0 = r0; x.t0 = t0; x.r1 = r1; x.t1 = t1;
        x.wa = wa; x.we = we; x.tn = tn; x.e_stall = es; x.e_f0 = f0; x.e_f1 = f1;
        return x;
    endfunction

    vec_t tab [17];

    // ------------------------------------------------------------------------
    // Reference model for the random run: a per-cycle history of which
    // instruction left D in which cycle. The instruction in stage k during
    // cycle n is the one accepted in cycle n-k; its remaining latency is its
    // entry Tnew minus the k-1 cycles it has already spent past E.
    // ------------------------------------------------------------------------
    bit         rec_w [0:NRAND];
    logic [4:0] rec_a [0:NRAND];
    int         rec_t [0:NRAND];
    int         floor_c;
    int         md_end;

    task automatic model_port(input int now, input logic [4:0] ra, input int tu,
                              output bit e_st, output int e_f);
        bit hit;
        int rem;
        int stg;
        hit = 0; rem = 0; stg = 0;
        for (int k = 1; k <= NSTAGE; k++) begin
            int c;
            c = now - k;
            if (!hit && c > floor_c && c >= 0 && rec_w[c] && rec_a[c] == ra && ra != 0) begin
                hit = 1;
                stg = k;
                rem = (rec_t[c] > k - 1) ? rec_t[c] - (k - 1) : 0;
            end
        end
        e_st = hit && (tu != 3) && (tu < rem);
        e_f  = (hit && rem == 0) ? stg : 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0);
        tick();

        //            rst chk v  r0 t0 r1 t1 wa we tn  st f0 f1
        tab[0]  = mkv(1, 0, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
        tab[1]  = mkv(0, 1, 0, 3, 0, 0, 3, 0, 0, 0, 0, 0, 0);  // reset state
        tab[2]  = mkv(0, 1, 1, 0, 3, 0, 3, 3, 1, 2, 0, 0, 0);  // lw $3
        tab[3]  = mkv(0, 1, 1, 3, 0, 0, 3, 0, 0, 0, 1, 0, 0);  // beq $3: stall 1
        tab[4]  = mkv(0, 1, 1, 3, 0, 0, 3, 0, 0, 0, 1, 0, 0);  // stall 2
        tab[5]  = mkv(0, 1, 1, 3, 0, 0, 3, 0, 0, 0, 0, 3, 0);  // released, fwd W
        tab[6]  = mkv(0, 1, 1, 0, 3, 0, 3, 5, 1, 0, 0, 0, 0);  // addu $5
        tab[7]  = mkv(0, 1, 1, 0, 3, 0, 3, 5, 1, 0, 0, 0, 0);  // addu $5
        tab[8]  = mkv(0, 1, 1, 5, 1, 5, 1, 0, 0, 0, 0, 1, 1);  // youngest wins
        tab[9]  = mkv(0, 1, 1, 0, 3, 0, 3, 0, 1, 2, 0, 0, 0);  // lw $0
        tab[10] = mkv(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // read $0
        tab[11] = mkv(0, 1, 1, 0, 3, 0, 3, 7, 1, 2, 0, 0, 0);  // lw $7
        tab[12] = mkv(0, 1, 1, 0, 0, 7, 3, 0, 0, 0, 0, 0, 0);  // unused port
        tab[13] = mkv(0, 1, 1, 0, 3, 7, 1, 0, 0, 0, 0, 0, 0);  // tuse == tnew
        tab[14] = mkv(0, 1, 0, 0, 3, 7, 0, 0, 0, 0, 0, 0, 3);  // tnew 0 in W
        tab[15] = mkv(0, 1, 0, 0, 3, 0, 3, 9, 1, 2, 0, 0, 0);  // invalid lw $9
        tab[16] = mkv(0, 1, 1, 9, 0, 0, 3, 0, 0, 0, 0, 0, 0);  // not tracked

        for (int i = 0; i < 17; i++) begin
            drive(tab[i].rst, tab[i].v, tab[i].r0, tab[i].r1, tab[i].t0, tab[i].t1,
                  tab[i].wa, tab[i].we, tab[i].tn, 0, 0, 0);
            #2;
            if (tab[i].do_chk) begin
                chk($sformatf("tab%0d_stall", i), int'(stall), int'(tab[i].e_stall));
                chk($sformatf("tab%0d_fwd0", i), int'(fwd_sel[1:0]), tab[i].e_f0);
                chk($sformatf("tab%0d_fwd1", i), int'(fwd_sel[3:2]), tab[i].e_f1);
                chk($sformatf("tab%0d_busy", i), int'(md_busy), 0);
            end
            tick();
        end

        // --------------------------------------------------------------------
        // Reset in the middle of a divide with a full scoreboard.
        // --------------------------------------------------------------------
        drive(1, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 0, 0, 3, 3, 0, 0, 0, 1, 1, 1); tick();           // div
        drive(0, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0); tick();           // bubble
        for (int r = 1; r <= 3; r++) begin
            drive(0, 1, 0, 0, 3, 3, 5'(r), 1, 0, 0, 0, 0); tick();   // addu $r
        end
        // count is 6 here; reset asserted while mfhi-like op reads $1/$3
        drive(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1);
        #2;
        chk("pre_rst_fwd0", int'(fwd_sel[1:0]), 3);
        chk("pre_rst_fwd1", int'(fwd_sel[3:2]), 1);
        chk("pre_rst_busy", int'(md_busy), int'(MD_ON));
        chk("pre_rst_stall", int'(stall), int'(MD_ON));
        tick();
        drive(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1);
        #2;
        chk("post_rst_stall", int'(stall), 0);
        chk("post_rst_fwd0", int'(fwd_sel[1:0]), 0);
        chk("post_rst_fwd1", int'(fwd_sel[3:2]), 0);
        chk("post_rst_busy", int'(md_busy), 0);
        tick();

`ifdef HAZARD_MD_EN
        // --------------------------------------------------------------------
        // div then mfhi; then mult then mflo.
        // --------------------------------------------------------------------
        drive(1, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 0, 0, 3, 3, 0, 0, 0, 1, 1, 1);
        #2;
        chk("div_issue_stall", int'(stall), 0);
        chk("div_issue_busy", int'(md_busy), 0);
        tick();
        for (int j = 1; j <= DIV_CYC; j++) begin
            drive(0, 1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1);               // mfhi
            #2;
            chk($sformatf("div_wait%0d_stall", j), int'(stall), 1);
            chk($sformatf("div_wait%0d_busy", j), int'(md_busy), 1);
            tick();
        end
        drive(0, 1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1);
        #2;
        chk("div_done_stall", int'(stall), 0);
        chk("div_done_busy", int'(md_busy), 0);
        tick();
        drive(0, 1, 0, 0, 3, 3, 0, 0, 0, 1, 0, 1);                   // mult
        #2;
        chk("mult_issue_stall", int'(stall), 0);
        tick();
        for (int j = 1; j <= MULT_CYC; j++) begin
            drive(0, 1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1);               // mflo
            #2;
            chk($sformatf("mult_wait%0d_stall", j), int'(stall), 1);
            chk($sformatf("mult_wait%0d_busy", j), int'(md_busy), 1);
            tick();
        end
        drive(0, 1, 0, 0, 3, 3, 0, 0, 0, 0, 0, 1);
        #2;
        chk("mult_done_stall", int'(stall), 0);
        chk("mult_done_busy", int'(md_busy), 0);
        tick();
`endif

        // --------------------------------------------------------------------
        // Randomized run against the history model.
        // --------------------------------------------------------------------
        drive(1, 0, 0, 0, 3, 3, 0, 0, 0, 0, 0, 0); tick();
        floor_c = -1;
        md_end  = 0;
        for (int n = 0; n <= NRAND; n++) begin
            rec_w[n] = 0; rec_a[n] = 0; rec_t[n] = 0;
        end
        for (int n = 0; n < NRAND; n++) begin
            bit         rst, v, we, ms, mdv, mu;
            logic [4:0] r0, r1, wa;
            logic [1:0] t0, t1, tn;
            bit         s0, s1, e_busy, e_stall;
            int         f0, f1;

            rst = ($urandom_range(0, 49) == 0);
            v   = ($urandom_range(0, 7) != 0);
            r0  = 5'($urandom_range(0, 3));
            r1  = 5'($urandom_range(0, 3));
            t0  = 2'($urandom_range(0, 3));
            t1  = 2'($urandom_range(0, 3));
            wa  = 5'($urandom_range(0, 3));
            we  = $urandom_range(0, 1) == 1;
            tn  = 2'($urandom_range(0, 3));
            mu  = MD_ON && ($urandom_range(0, 3) == 0);
            ms  = mu && ($urandom_range(0, 1) == 1);
            mdv = $urandom_range(0, 1) == 1;
            drive(rst, v, r0, r1, t0, t1, wa, we, tn, ms, mdv, mu);

            model_port(n, r0, int'(t0), s0, f0);
            model_port(n, r1, int'(t1), s1, f1);
            e_busy  = MD_ON && (n < md_end);
            e_stall = s0 || s1 || (v && mu && e_busy);

            #2;
            chk("rnd_stall", int'(stall), int'(e_stall));
            chk("rnd_fwd0", int'(fwd_sel[1:0]), f0);
            chk("rnd_fwd1", int'(fwd_sel[3:2]), f1);
            chk("rnd_busy", int'(md_busy), int'(e_busy));

            if (rst) begin
                floor_c = n;
                md_end  = 0;
            end else if (!e_stall) begin
                rec_w[n] = v && we && (wa != 0);
                rec_a[n] = wa;
                rec_t[n] = int'(tn);
                if (v && ms)
                    md_end = n + 1 + (mdv ? DIV_CYC : MULT_CYC);
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and forwarding controller for the five-stage MIPS pipeline. It sits beside the D stage. It keeps its own scoreboard of in-flight destination registers and their remaining Tnew for every stage after D. It compares that scoreboard against the Tuse of each source operand of the D-stage instruction and produces the stall and per-port forwarding selects. It also owns the multi-cycle mult/div busy counter that gates HI/LO access.

## Interface

Parameters:
- NREAD, 2: number of GPR read ports checked for the D instruction.
- NSTAGE, 3: tracked stages after D (1 = E, 2 = M, 3 = W).
- TW, 2: width of Tuse/Tnew fields.
- MULT_CYC, 5: busy cycles for mult/multu.
- DIV_CYC, 10: busy cycles for div/divu.

Derived: FW = $clog2(NSTAGE+1).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears the scoreboard and the busy counter.
- valid_d  in  1  the D stage holds a real instruction (not a bubble).
- rd_addr_d  in  NREAD*5  source register of port i, in bits [5i+4:5i].
- tuse_d  in  NREAD*TW  Tuse of port i; all-ones means the port is unused.
- wa_d  in  5  destination register of the D instruction.
- we_d  in  1  the D instruction writes the GPR.
- tnew_d  in  TW  Tnew of the D instruction, measured at entry to E.
- md_start_d  in  1  the D instruction starts mult/div.
- md_div_d  in  1  1 = div-class, 0 = mult-class.
- md_use_d  in  1  the D instruction touches HI/LO (mfhi/mflo/mthi/mtlo/mult/div).
- stall  out  1  freeze PC and F/D, and insert a bubble into E.
- fwd_sel  out  NREAD*FW  per port: 0 = register file, k = forward from stage k.
- md_busy  out  1  the mult/div unit is busy.

## Operation

- Scoreboard: NSTAGE entries, each {we, addr[4:0], tnew[TW-1:0]}.
- Every cycle, entry k+1 takes entry k, with tnew saturating-decremented (0 stays 0). Entry NSTAGE is discarded.
- Entry 1 loading:
  - When stall = 0, entry 1 takes {valid_d & we_d & (wa_d != 0), wa_d, tnew_d}.
  - When stall = 1, entry 1 takes the bubble {0, 0, 0}.
- Port match: for port i, entry k matches when we = 1 and addr = rd_addr_d[i] and addr != 0. Only the youngest (lowest k) matching entry is considered.
- Port stall: stall_i = match & (tuse_i < tnew_k). An unused port (tuse all-ones) can never stall.
- Forward select:
  - fwd_sel_i = k if the youngest match has tnew = 0.
  - Otherwise fwd_sel_i = 0; a later stage's forwarding supplies the value.
  - No match gives 0.
- Mult/div counter:
  - When valid_d & md_start_d & !stall, the counter loads DIV_CYC if md_div_d, else MULT_CYC.
  - Otherwise it decrements while nonzero.
  - md_busy = (cnt != 0).
- stall = OR of all stall_i, OR (valid_d & md_use_d & md_busy).
- A start arriving while busy cannot occur: md_use_d covers start instructions, so such a start is held in D.

## Timing

- stall, fwd_sel and md_busy are combinational from registered state plus current D inputs.
- The scoreboard and counter update on the next rising edge.
- md_busy rises in the cycle the start instruction occupies E and stays high for exactly MULT_CYC or DIV_CYC cycles.
- Reset, including mid-operation:
  - All entries become {0,0,0} and cnt becomes 0 on the next edge.
  - From that cycle: stall = 0 (no HI/LO stall), fwd_sel = 0, md_busy = 0.
- An instruction in D with valid_d = 0 never loads the scoreboard or the counter. It may still be reported as stalling, but is ignored downstream.

## Configuration

- HAZARD_MD_EN defined: the mult/div counter and HI/LO stall term are built in.
- HAZARD_MD_EN undefined:
  - md_* inputs are ignored and md_busy is tied 0.
  - stall is the GPR term only.
  - No counter flops.

## Structure

- Package hazard_pkg holds:
  - TW default.
  - FWD_GRF = 0.
  - TUSE_NONE = all-ones.
  - The sb_entry_t struct {we, addr, tnew}.
- One sub-module: md_busy_ctr (counter, load/decrement, md_busy), instantiated only under HAZARD_MD_EN.

## Test plan

- Load-use, two stall cycles:
  - Stimulus: lw $3 in D (we_d=1, tnew_d=2), next cycle beq reads $3 with tuse 0.
  - Required: stall = 1 for 2 cycles; on the third cycle stall = 0 and fwd_sel = 3.
- Youngest-match priority:
  - Stimulus: addu $5 in stage 2 (tnew 0) and addu $5 in stage 1 (tnew 0); D reads $5 with tuse 1.
  - Required: stall = 0, fwd_sel = 1.
- $0 destination:
  - Stimulus: lw $0 (tnew_d=2), then D reads $0 with tuse 0.
  - Required: stall = 0, fwd_sel = 0.
- Unused port:
  - Stimulus: port 1 tuse = all-ones and rd_addr matches an in-flight lw destination with tnew 2.
  - Required: stall = 0.
- Divide then read HI/LO (HAZARD_MD_EN, DIV_CYC = 10):
  - Stimulus: div, then mfhi immediately in D.
  - Required: md_busy high for 10 cycles, mfhi stalled 10 cycles, released on cycle 11.
- Reset mid-operation:
  - Stimulus: assert reset during a divide with cnt = 6 and the scoreboard full.
  - Required: next cycle md_busy = 0, stall = 0, every fwd_sel = 0.
